game_table_ram: RTL and testbench

//  Responder side of the game-table RAM interface. Holds the 10x10 playfield
//  (row 0 = top, row 9 = bottom) for the block-control FSM, which writes and

---
 rtl/game_table_ram.sv | 162 ++++++++++++++++
 tb/tb_game_table_ram.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/game_table_ram.sv
// game_table_ram
//   Responder side of the game-table RAM. Holds the ROWS x COLS playfield
//   (row 0 = top) for the block-control FSM, which reads and writes one row
//   per cycle. Also provides a registered display scan port, per-row full
//   flags and the battle "add garbage line" engine. That engine shifts the
//   table up one row and inserts a bottom row of ones with a single hole.
//
// Ports
//   clk_40M      system clock, all state on its rising edge
//   rst          synchronous active-high reset
//   ram_status   1 = write, 0 = read (controller command)
//   ram_addr     controller row address
//   ram_data_in  controller write data
//   ram_data_out registered read data (old data on read-during-write)
//   disp_addr    display scan row address
//   disp_data    registered display row data
//   game_addLine 1-cycle pulse requesting one garbage line
//   ram_busy     add-line engine active; controller writes are dropped
//   line_done    1-cycle pulse after a garbage line is fully inserted
//   row_full     bit k set when row k is all ones
//   top_out      sticky: a shift pushed a non-zero row 0 off the top
module game_table_ram #(
  parameter int ROWS        = 10,
  parameter int COLS        = 10,
  parameter int ADDR_W      = 4,
  parameter int MAX_PENDING = 3
) (
  input  logic              clk_40M,
  input  logic              rst,
  input  logic              ram_status,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [COLS-1:0]   ram_data_in,
  output logic [COLS-1:0]   ram_data_out,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [COLS-1:0]   disp_data,
  input  logic              game_addLine,
  output logic              ram_busy,
  output logic              line_done,
  output logic [ROWS-1:0]   row_full,
  output logic              top_out
);

  localparam int HOLE_W = $clog2(COLS);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [COLS-1:0] BIT0 = COLS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, INSERT} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  k;
  logic [HOLE_W-1:0]  hole_pos;
  logic [HOLE_W-1:0]  hole_q;
  logic [PEND_W-1:0]  pending;

  logic [COLS-1:0]    rows     [ROWS];
  logic [COLS-1:0]    rows_nxt [ROWS];

  logic               start;
  logic               deq;
  logic               enq;
  logic [ADDR_W-1:0]  k_plus;

  assign k_plus = k + ADDR_W'(1);

  // A request is taken from the queue first; a new pulse arriving while the
  // engine is busy, or alongside a dequeue, is queued instead.
  assign start = (state == IDLE) && (game_addLine || (pending != '0));
  assign deq   = (state == IDLE) && (pending != '0);
  assign enq   = game_addLine && !((state == IDLE) && (pending == '0));

  // Next table contents: the engine owns the table while busy, otherwise
  // the controller may write one in-range row.
  always_comb begin
    rows_nxt = rows;
    case (state)
      SHIFT:  rows_nxt[k] = rows[k_plus];
      INSERT: rows_nxt[ROWS-1] = ~(BIT0 << hole_q);
      default: begin
        if (ram_status && (ram_addr < ADDR_W'(ROWS)))
          rows_nxt[ram_addr] = ram_data_in;
      end
    endcase
  end

  // Table storage, read ports and full flags
  always_ff @(posedge clk_40M) begin
    if (rst) begin
      rows         <= '{default: '0};
      ram_data_out <= '0;
      disp_data    <= '0;
      row_full     <= '0;
    end else begin
      rows         <= rows_nxt;
      ram_data_out <= (ram_addr  < ADDR_W'(ROWS)) ? rows[ram_addr]  : '0;
      disp_data    <= (disp_addr < ADDR_W'(ROWS)) ? rows[disp_addr] : '0;
      for (int unsigned r = 0; r < ROWS; r++)
        row_full[r] <= &rows_nxt[r];
    end
  end

  // Free-running hole position
  always_ff @(posedge clk_40M) begin
    if (rst)
      hole_pos <= '0;
    else if (hole_pos == HOLE_W'(COLS - 1))
      hole_pos <= '0;
    else
      hole_pos <= hole_pos + HOLE_W'(1);
  end

  // Request queue
  always_ff @(posedge clk_40M) begin
    if (rst)
      pending <= '0;
    else if (deq && !enq)
      pending <= pending - PEND_W'(1);
    else if (enq && !deq && (pending != PEND_W'(MAX_PENDING)))
      pending <= pending + PEND_W'(1);
  end

  // Add-line engine
  always_ff @(posedge clk_40M) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      hole_q    <= '0;
      ram_busy  <= 1'b0;
      line_done <= 1'b0;
      top_out   <= 1'b0;
    end else begin
      line_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            hole_q   <= hole_pos;
            k        <= '0;
            state    <= SHIFT;
            ram_busy <= 1'b1;
            if (rows[0] != '0)
              top_out <= 1'b1;
          end
        end
        SHIFT: begin
          if (k == ADDR_W'(ROWS - 2))
            state <= INSERT;
          else
            k <= k_plus;
        end
        INSERT: begin
          state     <= IDLE;
          ram_busy  <= 1'b0;
          line_done <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          ram_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_table_ram.sv
// tb_game_table_ram
//   Directed test of game_table_ram: controller read/write, out-of-range
//   addresses, garbage-line insertion, request queue saturation, top-out
//   flag, writes while busy and reset mid-shift.
module tb_game_table_ram;

  logic       clk_40M = 1'b0;
  logic       rst;
  logic       ram_status;
  logic [3:0] ram_addr;
  logic [9:0] ram_data_in;
  logic [9:0] ram_data_out;
  logic [3:0] disp_addr;
  logic [9:0] disp_data;
  logic       game_addLine;
  logic       ram_busy;
  logic       line_done;
  logic [9:0] row_full;
  logic       top_out;

  game_table_ram #(
    .ROWS(10),
    .COLS(10),
    .ADDR_W(4),
    .MAX_PENDING(3)
  ) dut (
    .clk_40M      (clk_40M),
    .rst          (rst),
    .ram_status   (ram_status),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .game_addLine (game_addLine),
    .ram_busy     (ram_busy),
    .line_done    (line_done),
    .row_full     (row_full),
    .top_out      (top_out)
  );

  always #12 clk_40M = ~clk_40M;

  // Reference hole counter: 0..9, +1 per cycle, cleared by reset
  int unsigned tb_hole;
  always @(posedge clk_40M) begin
    if (rst)             tb_hole <= 0;
    else if (tb_hole == 9) tb_hole <= 0;
    else                 tb_hole <= tb_hole + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [9:0] exp_rows [10];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one cycle; sample busy/done of the new cycle on the falling edge
  task automatic step();
    @(negedge clk_40M);
    if (ram_busy)  busy_cnt++;
    if (line_done) done_cnt++;
  endtask

  task automatic wr(input logic [3:0] a, input logic [9:0] d);
    ram_status  = 1'b1;
    ram_addr    = a;
    ram_data_in = d;
    step();
    ram_status  = 1'b0;
  endtask

  task automatic pulse_add();
    game_addLine = 1'b1;
    step();
    game_addLine = 1'b0;
  endtask

  task automatic model_line(input int unsigned h);
    logic [9:0] one;
    one = 10'd1;
    for (int r = 0; r < 9; r++) exp_rows[r] = exp_rows[r+1];
    exp_rows[9] = ~(one << h);
  endtask

  task automatic check_table(input string tag);
    for (int r = 0; r < 10; r++) begin
      disp_addr = 4'(r);
      step();
      check($sformatf("%s_r%0d", tag, r), 32'(disp_data), 32'(exp_rows[r]));
    end
  endtask

  task automatic wait_hole(input int unsigned h);
    for (int i = 0; i < 20; i++) begin
      if (tb_hole == h) return;
      step();
    end
    check("wait_hole", tb_hole, h);
  endtask

  int unsigned h0;

  initial begin
    rst = 1'b1; ram_status = 1'b0; ram_addr = '0; ram_data_in = '0;
    disp_addr = '0; game_addLine = 1'b0;
    for (int r = 0; r < 10; r++) exp_rows[r] = '0;
    step(); step();

    check("rst_rdata",  32'(ram_data_out), 0);
    check("rst_ddata",  32'(disp_data), 0);
    check("rst_full",   32'(row_full), 0);
    check("rst_busy",   32'(ram_busy), 0);
    check("rst_done",   32'(line_done), 0);
    check("rst_topout", 32'(top_out), 0);
    rst = 1'b0;
    step();

    // Write row 4, old data on read-during-write, then new data
    wr(4, 10'h3FF);
    check("rdw_old", 32'(ram_data_out), 0);
    check("full4", 32'(row_full), 32'h010);
    step();
    check("rd4", 32'(ram_data_out), 32'h3FF);
    exp_rows[4] = 10'h3FF;

    // Out-of-range write and read
    wr(12, 10'h3FF);
    check("rd12", 32'(ram_data_out), 0);
    check("full_after12", 32'(row_full), 32'h010);
    check_table("oor");

    // Single line with hole 3
    wr(4, 10'h000);
    wr(9, 10'h001);
    exp_rows[4] = '0; exp_rows[9] = 10'h001;
    wait_hole(3);
    busy_cnt = 0; done_cnt = 0;
    pulse_add();
    for (int i = 0; i < 11; i++) step();
    check("l1_busy", busy_cnt, 10);
    check("l1_done", done_cnt, 1);
    model_line(3);
    check("l1_r9", 32'(exp_rows[9]), 32'h3F7);
    check("l1_full", 32'(row_full), 0);
    check_table("l1");

    // Queue saturation: 1 + 5 pulses -> 4 lines
    busy_cnt = 0; done_cnt = 0;
    h0 = tb_hole;
    pulse_add();
    for (int i = 0; i < 5; i++) begin
      pulse_add();
      step();
    end
    for (int i = 0; i < 49; i++) step();
    check("q_busy", busy_cnt, 40);
    check("q_done", done_cnt, 4);
    for (int unsigned j = 0; j < 4; j++) model_line((h0 + j) % 10);
    check("q_topout", 32'(top_out), 0);
    check_table("q");

    // Top-out plus write during SHIFT k=5
    wr(0, 10'h010);
    exp_rows[0] = 10'h010;
    busy_cnt = 0; done_cnt = 0;
    h0 = tb_hole;
    pulse_add();
    for (int i = 0; i < 5; i++) step();
    wr(2, 10'h3FF);
    for (int i = 0; i < 6; i++) step();
    model_line(h0);
    check("to_busy", busy_cnt, 10);
    check("to_done", done_cnt, 1);
    check("topout", 32'(top_out), 1);
    check("to_full2", 32'(row_full[2]), 0);
    check_table("to");
    check("topout_sticky", 32'(top_out), 1);

    // Reset at SHIFT k=5 aborts the line
    wr(9, 10'h0AA);
    pulse_add();
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_busy", 32'(ram_busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ab_busy", 32'(ram_busy), 0);
    check("ab_topout", 32'(top_out), 0);
    for (int r = 0; r < 10; r++) exp_rows[r] = '0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 15; i++) step();
    check("ab_busy_after", busy_cnt, 0);
    check("ab_done_after", done_cnt, 0);
    check("ab_full", 32'(row_full), 0);
    check_table("ab");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
